fft_frame_capture: RTL and testbench

Output-side frame collector for the FFT256 streaming core. It sits on the core's out_valid/dout_r/dout_i stream and watches the core's in_valid to time the input-to-output latency. It stores one 256-point result frame in a local buffer, optionally undoing bit-reversed ordering, and flags timeout or overrun. A host reads the frame back through a registered random-access port.

---
 rtl/fft_pkg.sv | 22 ++
 rtl/fft_frame_ram.sv | 30 +++
 rtl/fft_frame_capture.sv | 140 ++++++++++++++
 tb/tb_fft_frame_capture.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared defaults, capture state encoding and the bit-reversal helper for the
// FFT256 output-side frame collector.
package fft_pkg;
   localparam int FFT_SIZE      = 256;
   localparam int OUT_WIDTH     = 16;
   localparam int ADDR_W        = 8;
   localparam int LATENCY_LIMIT = 516;
   localparam int LAT_W         = 10;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WAIT    = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_READY   = 2'd3
   } cap_state_t;

   function automatic logic [ADDR_W-1:0] bitrev(input logic [ADDR_W-1:0] a);
      logic [ADDR_W-1:0] r;
      for (int b = 0; b < ADDR_W; b++) r[b] = a[ADDR_W-1-b];
      return r;
   endfunction
endpackage

// File: rtl/fft_frame_ram.sv
// Frame buffer: one write port, one registered read port. Storage is not reset;
// only the read register is, so the read bus comes out of reset at zero.
module fft_frame_ram #(
   parameter int DEPTH = 256,
   parameter int AW    = 8,
   parameter int DW    = 32
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [DW-1:0] i_wdata,
   input  logic          i_re,
   input  logic [AW-1:0] i_raddr,
   output logic [DW-1:0] o_rdata
);
   logic [DW-1:0] r_mem [DEPTH];
   logic [DW-1:0] r_rdata;

   always_ff @(posedge i_clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)  r_rdata <= '0;
      else if (i_re) r_rdata <= r_mem[i_raddr];
   end

   assign o_rdata = r_rdata;
endmodule

// File: rtl/fft_frame_capture.sv
// Collects one FFT result frame after the input burst ends, optionally undoing
// bit-reversed order, and serves it to a host through a 1-cycle read port.
module fft_frame_capture #(
   parameter int FFT_SIZE      = fft_pkg::FFT_SIZE,
   parameter int OUT_WIDTH     = fft_pkg::OUT_WIDTH,
   parameter int LATENCY_LIMIT = fft_pkg::LATENCY_LIMIT,
   parameter int ADDR_W        = fft_pkg::ADDR_W
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_in_valid,
   input  logic                 i_out_valid,
   input  logic [OUT_WIDTH-1:0] i_dout_r,
   input  logic [OUT_WIDTH-1:0] i_dout_i,
   input  logic                 i_bitrev_en,
   input  logic                 i_frame_ack,
   input  logic                 i_rd_en,
   input  logic [ADDR_W-1:0]    i_rd_addr,
   output logic [OUT_WIDTH-1:0] o_rd_data_r,
   output logic [OUT_WIDTH-1:0] o_rd_data_i,
   output logic                 o_rd_valid,
   output logic                 o_frame_ready,
   output logic                 o_busy,
   output logic                 o_timeout,
   output logic                 o_overrun,
   output logic [9:0]           o_latency
);
   import fft_pkg::*;

   cap_state_t          r_state;
   logic                r_in_valid_d;
   logic [9:0]          r_lat_cnt;
   logic [9:0]          r_latency;
   logic [ADDR_W-1:0]   r_wr_idx;
   logic                r_bitrev;
   logic                r_frame_ready;
   logic                r_timeout;
   logic                r_overrun;
   logic                r_rd_valid;

   logic                w_fall;
   logic                w_we;
   logic [ADDR_W-1:0]   w_widx;
   logic [ADDR_W-1:0]   w_waddr;
   logic                w_re;
   logic [2*OUT_WIDTH-1:0] w_rdata;

   assign w_fall  = r_in_valid_d & ~i_in_valid;
   // The first sample lands in WAIT, before wr_idx has advanced past 0.
   assign w_we    = i_out_valid && (r_state == ST_WAIT || r_state == ST_CAPTURE);
   assign w_widx  = (r_state == ST_WAIT) ? '0 : r_wr_idx;
   assign w_waddr = r_bitrev ? bitrev(w_widx) : w_widx;
   assign w_re    = i_rd_en && (r_state == ST_READY);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state       <= ST_IDLE;
         r_in_valid_d  <= 1'b0;
         r_lat_cnt     <= '0;
         r_latency     <= '0;
         r_wr_idx      <= '0;
         r_bitrev      <= 1'b0;
         r_frame_ready <= 1'b0;
         r_timeout     <= 1'b0;
         r_overrun     <= 1'b0;
         r_rd_valid    <= 1'b0;
      end else begin
         r_in_valid_d <= i_in_valid;
         r_rd_valid   <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (i_out_valid) r_overrun <= 1'b1;
               // A new frame starts clean, even if a stray sample arrives on the same edge.
               if (w_fall) begin
                  r_state   <= ST_WAIT;
                  r_lat_cnt <= '0;
                  r_wr_idx  <= '0;
                  r_timeout <= 1'b0;
                  r_overrun <= 1'b0;
                  r_bitrev  <= i_bitrev_en;
               end
            end
            ST_WAIT: begin
               if (i_out_valid) begin
                  r_latency <= r_lat_cnt;
                  r_wr_idx  <= ADDR_W'(1);
                  r_state   <= ST_CAPTURE;
               end else if (r_lat_cnt == 10'(LATENCY_LIMIT)) begin
                  r_timeout <= 1'b1;
                  r_state   <= ST_IDLE;
               end else begin
                  r_lat_cnt <= r_lat_cnt + 10'd1;
               end
            end
            ST_CAPTURE: begin
               if (i_out_valid) begin
                  r_wr_idx <= r_wr_idx + ADDR_W'(1);
                  if (r_wr_idx == ADDR_W'(FFT_SIZE-1)) begin
                     r_state       <= ST_READY;
                     r_frame_ready <= 1'b1;
                  end
               end
            end
            ST_READY: begin
               r_rd_valid <= i_rd_en;
               if (i_out_valid) r_overrun <= 1'b1;
               if (i_frame_ack) begin
                  r_frame_ready <= 1'b0;
                  r_state       <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   fft_frame_ram #(
      .DEPTH (FFT_SIZE),
      .AW    (ADDR_W),
      .DW    (2*OUT_WIDTH)
   ) u_ram (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_we    (w_we),
      .i_waddr (w_waddr),
      .i_wdata ({i_dout_r, i_dout_i}),
      .i_re    (w_re),
      .i_raddr (i_rd_addr),
      .o_rdata (w_rdata)
   );

   assign o_rd_data_r   = w_rdata[2*OUT_WIDTH-1:OUT_WIDTH];
   assign o_rd_data_i   = w_rdata[OUT_WIDTH-1:0];
   assign o_rd_valid    = r_rd_valid;
   assign o_frame_ready = r_frame_ready;
   assign o_busy        = (r_state == ST_WAIT) || (r_state == ST_CAPTURE);
   assign o_timeout     = r_timeout;
   assign o_overrun     = r_overrun;
   assign o_latency     = r_latency;
endmodule

// File: tb/tb_fft_frame_capture.sv
// Directed bench for fft_frame_capture: normal, bit-reversed, timeout, gapped,
// overrun and mid-frame reset scenarios with hand-computed expectations.
module tb_fft_frame_capture;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, out_valid, bitrev_en, frame_ack, rd_en;
   logic [15:0] dout_r, dout_i;
   logic [7:0]  rd_addr;
   logic [15:0] rd_data_r, rd_data_i;
   logic        rd_valid, frame_ready, busy, timeout, overrun;
   logic [9:0]  latency;

   int checks = 0;
   int errors = 0;

   fft_frame_capture dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .i_out_valid(out_valid),
      .i_dout_r(dout_r), .i_dout_i(dout_i), .i_bitrev_en(bitrev_en),
      .i_frame_ack(frame_ack), .i_rd_en(rd_en), .i_rd_addr(rd_addr),
      .o_rd_data_r(rd_data_r), .o_rd_data_i(rd_data_i), .o_rd_valid(rd_valid),
      .o_frame_ready(frame_ready), .o_busy(busy), .o_timeout(timeout),
      .o_overrun(overrun), .o_latency(latency)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   function automatic int smp_r(input int k, input int m);
      return (m == 2) ? 3*k + 7 : k;
   endfunction

   function automatic int smp_i(input int k, input int m);
      return (m == 2) ? k - 200 : -k;
   endfunction

   // Input burst, then the edge that registers its falling edge (WAIT, lat_cnt=0),
   // then `lat` idle edges so the first sample lands with lat_cnt == lat.
   task automatic start_frame(input bit br, input int lat);
      bitrev_en = br;
      in_valid  = 1'b1;
      repeat (256) @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      repeat (lat) @(negedge clk);
   endtask

   task automatic send_frame(input int n, input int m, input bit gap, input bit ack_last);
      for (int k = 0; k < n; k++) begin
         if (n == 256 && k == 255) chk("ready_before_last", frame_ready, 0);
         out_valid = 1'b1;
         dout_r    = 16'(smp_r(k, m));
         dout_i    = 16'(smp_i(k, m));
         frame_ack = ack_last && (k == n-1);
         @(negedge clk);
         out_valid = 1'b0;
         frame_ack = 1'b0;
         if (gap) @(negedge clk);
      end
   endtask

   task automatic rd_chk(input string tag, input int addr, input int er, input int ei);
      rd_en   = 1'b1;
      rd_addr = 8'(addr);
      @(negedge clk);
      rd_en = 1'b0;
      chk({tag, "_vld"}, rd_valid, 1);
      chk({tag, "_r"}, $signed(rd_data_r), er);
      chk({tag, "_i"}, $signed(rd_data_i), ei);
   endtask

   task automatic ack();
      frame_ack = 1'b1;
      @(negedge clk);
      frame_ack = 1'b0;
      chk("ack_clears_ready", frame_ready, 0);
      @(negedge clk);
   endtask

   initial begin
      int bad;
      rst_n = 1'b0; in_valid = 0; out_valid = 0; bitrev_en = 0; frame_ack = 0;
      rd_en = 0; rd_addr = 0; dout_r = 0; dout_i = 0;
      repeat (3) @(negedge clk);
      chk("rst_ready", frame_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_timeout", timeout, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_latency", latency, 0);
      chk("rst_rd_valid", rd_valid, 0);
      chk("rst_rd_data", rd_data_r, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Normal frame, natural order
      start_frame(1'b0, 300);
      chk("wait_busy", busy, 1);
      send_frame(256, 0, 1'b0, 1'b0);
      chk("n_latency", latency, 300);
      chk("n_ready", frame_ready, 1);
      chk("n_busy", busy, 0);
      chk("n_timeout", timeout, 0);
      chk("n_overrun", overrun, 0);
      rd_chk("n_a17", 17, 17, -17);
      rd_chk("n_a255", 255, 255, -255);
      rd_chk("n_a0", 0, 0, 0);
      @(negedge clk);
      chk("rd_valid_pulse", rd_valid, 0);
      ack();

      // Bit-reversed frame
      start_frame(1'b1, 300);
      send_frame(256, 0, 1'b0, 1'b0);
      rd_chk("b_a80", 8'h80, 1, -1);
      rd_chk("b_aFF", 8'hFF, 255, -255);
      rd_chk("b_a01", 8'h01, 128, -128);
      rd_chk("b_a06", 8'h06, 96, -96);
      ack();

      // Timeout: out_valid never comes
      start_frame(1'b0, 516);
      chk("to_before", timeout, 0);
      chk("to_busy_before", busy, 1);
      @(negedge clk);
      chk("to_set", timeout, 1);
      chk("to_idle", busy, 0);
      chk("to_ready", frame_ready, 0);
      rd_en = 1'b1; rd_addr = 8'd3;
      @(negedge clk);
      rd_en = 1'b0;
      chk("idle_rd_valid", rd_valid, 0);

      // Gapped output, ack coincident with last sample is ignored
      start_frame(1'b0, 10);
      chk("g_timeout_cleared", timeout, 0);
      send_frame(256, 0, 1'b1, 1'b1);
      chk("g_ready", frame_ready, 1);
      chk("g_latency", latency, 10);
      bad = 0;
      for (int a = 0; a < 256; a++) begin
         rd_en = 1'b1; rd_addr = 8'(a);
         @(negedge clk);
         if (!rd_valid || $signed(rd_data_r) != a || $signed(rd_data_i) != -a) bad++;
      end
      rd_en = 1'b0;
      chk("g_all_samples_bad", bad, 0);

      // Overrun in READY
      out_valid = 1'b1; dout_r = 16'd999; dout_i = 16'd999;
      @(negedge clk);
      out_valid = 1'b0;
      chk("ov_set", overrun, 1);
      chk("ov_still_ready", frame_ready, 1);
      rd_chk("ov_a0", 0, 0, 0);
      rd_chk("ov_a5", 5, 5, -5);
      ack();
      chk("ov_sticky", overrun, 1);

      // Reset in the middle of CAPTURE
      start_frame(1'b0, 3);
      chk("rm_overrun_cleared", overrun, 0);
      send_frame(100, 2, 1'b0, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("rm_busy", busy, 0);
      chk("rm_latency", latency, 0);
      chk("rm_rd_data_r", rd_data_r, 0);
      chk("rm_rd_data_i", rd_data_i, 0);
      chk("rm_ready", frame_ready, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      start_frame(1'b0, 5);
      send_frame(256, 2, 1'b0, 1'b0);
      chk("rm2_latency", latency, 5);
      chk("rm2_ready", frame_ready, 1);
      rd_chk("rm2_a0", 0, 7, -200);
      rd_chk("rm2_a150", 150, 457, -50);
      rd_chk("rm2_a255", 255, 772, 55);
      ack();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
